// File: rtl/trx_status_monitor.sv
// trx_status_monitor
// N-channel status monitor for LVDS transceivers, in the test-core clock domain.
//   - Counts replay and CRC-error events per channel in saturating counters.
//   - Stretches event pulses and link state into LED indications, plus a heartbeat.
//   - Serves counter readout through a one-cycle request/response port.
//
// Optional feature macro: TRX_STATUS_MON_CLR_ON_RD_EN
//   defined   : a read also clears both counters of the selected channel
//               (the read returns the pre-clear value; a rise in the read
//               cycle is counted after the clear).
//   undefined : reads are non-destructive; only i_clr clears.
//
// Ports:
//   i_clk       monitor clock (all inputs already synchronous to it)
//   i_arst_n    asynchronous active-low reset
//   i_link_up   per-channel link-up level
//   i_evt_rply  per-channel replay level, each rising edge is one event
//   i_evt_crc   per-channel CRC-error level, each rising edge is one event
//   i_clr       synchronous clear of all counters
//   i_rd        one-cycle read strobe
//   i_rd_sel    channel to read (>= CHANNELS returns zeros)
//   o_rd_data   {crc_cnt, rply_cnt} of the selected channel
//   o_rd_valid  one-cycle pulse qualifying o_rd_data
//   o_led       bit 0 heartbeat, bit 2c+1 link LED, bit 2c+2 activity LED
module trx_status_monitor #(
    parameter int unsigned CHANNELS         = 2,
    parameter int unsigned CNT_WIDTH        = 16,
    parameter int unsigned STRETCH_CYCLES   = 8_333_333,
    parameter int unsigned HEARTBEAT_CYCLES = 83_333_333
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic [CHANNELS-1:0]          i_link_up,
    input  logic [CHANNELS-1:0]          i_evt_rply,
    input  logic [CHANNELS-1:0]          i_evt_crc,
    input  logic                         i_clr,
    input  logic                         i_rd,
    input  logic [$clog2(CHANNELS):0]    i_rd_sel,
    output logic [2*CNT_WIDTH-1:0]       o_rd_data,
    output logic                         o_rd_valid,
    output logic [2*CHANNELS:0]          o_led
);

    localparam int unsigned SEL_W = $clog2(CHANNELS) + 1;
    localparam int unsigned ST_W  = $clog2(STRETCH_CYCLES + 1);
    localparam int unsigned HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam int unsigned LED_W = 2 * CHANNELS + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [ST_W-1:0]      ST_LOAD = ST_W'(STRETCH_CYCLES);
    localparam logic [HB_W-1:0]      HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    logic [CHANNELS-1:0]  rply_q;
    logic [CHANNELS-1:0]  crc_q;
    logic [CHANNELS-1:0]  rply_rise;
    logic [CHANNELS-1:0]  crc_rise;

    logic [CNT_WIDTH-1:0] rply_cnt   [CHANNELS];
    logic [CNT_WIDTH-1:0] crc_cnt    [CHANNELS];
    logic [CNT_WIDTH-1:0] rply_cnt_d [CHANNELS];
    logic [CNT_WIDTH-1:0] crc_cnt_d  [CHANNELS];

    logic [ST_W-1:0]      stretch_cnt   [CHANNELS];
    logic [ST_W-1:0]      stretch_cnt_d [CHANNELS];

    logic [HB_W-1:0]      hb_cnt;
    logic                 hb;
    logic                 hb_tick;
    logic                 hb_d;

    logic [2*CNT_WIDTH-1:0] rd_data_d;
    logic [LED_W-1:0]       led_d;

`ifdef TRX_STATUS_MON_CLR_ON_RD_EN
    logic [CHANNELS-1:0]  rd_clr;
`endif

    // Edge detect on the event levels
    always_comb begin
        rply_rise = i_evt_rply & ~rply_q;
        crc_rise  = i_evt_crc  & ~crc_q;
    end

`ifdef TRX_STATUS_MON_CLR_ON_RD_EN
    // Destructive read: only a selected, existing channel is cleared
    always_comb begin
        rd_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rd_clr[c] = i_rd && (i_rd_sel == SEL_W'(c));
        end
    end
`endif

    // Counter next state: i_clr wins, then optional read-clear, then saturating increment
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            rply_cnt_d[c] = rply_cnt[c];
            crc_cnt_d[c]  = crc_cnt[c];
            if (i_clr) begin
                rply_cnt_d[c] = '0;
                crc_cnt_d[c]  = '0;
            end else begin
`ifdef TRX_STATUS_MON_CLR_ON_RD_EN
                if (rd_clr[c]) begin
                    rply_cnt_d[c] = '0;
                    crc_cnt_d[c]  = '0;
                end
`endif
                if (rply_rise[c] && (rply_cnt_d[c] != CNT_MAX)) begin
                    rply_cnt_d[c] = rply_cnt_d[c] + CNT_WIDTH'(1);
                end
                if (crc_rise[c] && (crc_cnt_d[c] != CNT_MAX)) begin
                    crc_cnt_d[c] = crc_cnt_d[c] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Read mux over the pre-update counter values; out-of-range select yields zeros
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_rd_sel == SEL_W'(c)) begin
                rd_data_d = {crc_cnt[c], rply_cnt[c]};
            end
        end
    end

    // Activity stretch: any rise (re)loads, otherwise count down to zero
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            stretch_cnt_d[c] = stretch_cnt[c];
            if (rply_rise[c] || crc_rise[c]) begin
                stretch_cnt_d[c] = ST_LOAD;
            end else if (stretch_cnt[c] != '0) begin
                stretch_cnt_d[c] = stretch_cnt[c] - ST_W'(1);
            end
        end
    end

    // Heartbeat toggles at terminal count of the free-running counter
    always_comb begin
        hb_tick = (hb_cnt == HB_LAST);
        hb_d    = hb ^ hb_tick;
    end

    // LED next state, built from next-state values so all LEDs align with hb
    always_comb begin
        led_d    = '0;
        led_d[0] = hb_d;
        for (int c = 0; c < CHANNELS; c++) begin
            led_d[2*c+1] = i_link_up[c] | hb_d;
            led_d[2*c+2] = (stretch_cnt_d[c] != '0);
        end
    end

    // Event edge registers and counters
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rply_q <= '0;
            crc_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                rply_cnt[c]    <= '0;
                crc_cnt[c]     <= '0;
                stretch_cnt[c] <= '0;
            end
        end else begin
            rply_q <= i_evt_rply;
            crc_q  <= i_evt_crc;
            for (int c = 0; c < CHANNELS; c++) begin
                rply_cnt[c]    <= rply_cnt_d[c];
                crc_cnt[c]     <= crc_cnt_d[c];
                stretch_cnt[c] <= stretch_cnt_d[c];
            end
        end
    end

    // Heartbeat counter
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else begin
            hb_cnt <= hb_tick ? '0 : hb_cnt + HB_W'(1);
            hb     <= hb_d;
        end
    end

    // Read response; data holds when no read is issued
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd;
            if (i_rd) begin
                o_rd_data <= rd_data_d;
            end
        end
    end

    // LED outputs
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_led <= '0;
        end else begin
            o_led <= led_d;
        end
    end

endmodule

// File: tb/tb_trx_status_monitor.sv
// Directed bench for trx_status_monitor: main instance (16-bit counters) plus a
// 4-bit-counter instance sharing the same stimulus to reach saturation quickly.
module tb_trx_status_monitor;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned SC = 10;
    localparam int unsigned HB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   link_up;
    logic [CH-1:0]   evt_rply;
    logic [CH-1:0]   evt_crc;
    logic            clr;
    logic            rd;
    logic [1:0]      rd_sel;
    logic [2*CW-1:0] rd_data;
    logic            rd_valid;
    logic [2*CH:0]   led;
    logic [2*SW-1:0] sat_rd_data;
    logic            sat_rd_valid;
    logic [2*CH:0]   sat_led;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trx_status_monitor #(
        .CHANNELS(CH), .CNT_WIDTH(CW), .STRETCH_CYCLES(SC), .HEARTBEAT_CYCLES(HB)
    ) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_link_up(link_up),
        .i_evt_rply(evt_rply), .i_evt_crc(evt_crc), .i_clr(clr),
        .i_rd(rd), .i_rd_sel(rd_sel), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_led(led)
    );

    trx_status_monitor #(
        .CHANNELS(CH), .CNT_WIDTH(SW), .STRETCH_CYCLES(SC), .HEARTBEAT_CYCLES(HB)
    ) dut_sat (
        .i_clk(clk), .i_arst_n(rst_n), .i_link_up(link_up),
        .i_evt_rply(evt_rply), .i_evt_crc(evt_crc), .i_clr(clr),
        .i_rd(rd), .i_rd_sel(rd_sel), .o_rd_data(sat_rd_data),
        .o_rd_valid(sat_rd_valid), .o_led(sat_led)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input bit is_crc);
        if (is_crc) evt_crc[ch] = 1'b1; else evt_rply[ch] = 1'b1;
        tick();
        if (is_crc) evt_crc[ch] = 1'b0; else evt_rply[ch] = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [1:0] sel, input logic [31:0] exp, input string tag);
        rd     = 1'b1;
        rd_sel = sel;
        tick();
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp);
        rd = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        link_up  = '0;
        evt_rply = '0;
        evt_crc  = '0;
        clr      = 1'b0;
        rd       = 1'b0;
        rd_sel   = '0;

        // Reset values
        #2;
        check("rst_led", led, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        #10;
        rst_n = 1'b1;

        // Heartbeat and blinking link LEDs (link down): toggle every 4 cycles
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("hb_led0_k%0d", k), led[0], (k / 4) % 2);
            check($sformatf("hb_link0_k%0d", k), led[1], (k / 4) % 2);
            check($sformatf("hb_link1_k%0d", k), led[3], (k / 4) % 2);
        end
        check("act0_idle", led[2], 0);
        link_up = 2'b01;
        check("link0_before_edge", led[1], 0);
        tick();
        check("link0_up", led[1], 1);
        check("hb_k11", led[0], 0);
        check("link1_still_blink", led[3], 0);
        link_up = 2'b11;

        // Three replay events on channel 1
        for (int i = 0; i < 3; i++) pulse(1, 1'b0);
        do_read(2'd1, 32'h0000_0003, "rd_ch1_3");
        tick();
        check("rd_valid_drop", rd_valid, 0);
        check("rd_data_hold", rd_data, 32'h0000_0003);
        do_read(2'd0, 32'h0000_0000, "rd_ch0_0");

        // Back-to-back reads including out-of-range selects
        do_read(2'd1, 32'h0000_0003, "b2b_ch1");
        do_read(2'd3, 32'h0000_0000, "b2b_sel3");
        do_read(2'd2, 32'h0000_0000, "b2b_sel2");
        tick();
        check("b2b_end_valid", rd_valid, 0);
        check("b2b_end_hold", rd_data, 0);

        // Simultaneous replay and CRC rise on channel 0
        evt_rply[0] = 1'b1;
        evt_crc[0]  = 1'b1;
        tick();
        evt_rply[0] = 1'b0;
        evt_crc[0]  = 1'b0;
        tick();
        do_read(2'd0, 32'h0001_0001, "both_ch0");

        // Clear wins over a rise in the same cycle
        clr         = 1'b1;
        evt_rply[0] = 1'b1;
        tick();
        clr         = 1'b0;
        evt_rply[0] = 1'b0;
        tick();
        do_read(2'd0, 32'h0000_0000, "clr_ch0");
        do_read(2'd1, 32'h0000_0000, "clr_ch1");

        // Saturation on the 4-bit instance: 17 then 18 rises
        for (int i = 0; i < 17; i++) pulse(0, 1'b0);
        do_read(2'd0, 32'h0000_0011, "sat_main17");
        check("sat_valid", sat_rd_valid, 1);
        check("sat_data15", sat_rd_data, 8'h0F);
        pulse(0, 1'b0);
        do_read(2'd0, 32'h0000_0012, "sat_main18");
        check("sat_data_stuck", sat_rd_data, 8'h0F);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        do_read(2'd0, 32'h0000_0000, "sat_clr_main");
        check("sat_clr_data", sat_rd_data, 8'h00);

        // Stretch: rises in cycle 0 and cycle 5 -> LED high for cycles 1..15
        check("act1_pre", led[4], 0);
        evt_crc[1] = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick();
            evt_crc[1] = (j == 5);
            check($sformatf("stretch_c%0d", j), led[4], (j >= 1 && j <= 15) ? 1 : 0);
        end

        // Read with a concurrent rise on channel 0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulse(0, 1'b0);
        pulse(0, 1'b0);
        rd          = 1'b1;
        rd_sel      = 2'd0;
        evt_rply[0] = 1'b1;
        tick();
        evt_rply[0] = 1'b0;
        check("cor_first_valid", rd_valid, 1);
        check("cor_first_data", rd_data, 32'h0000_0002);
        tick();
        rd = 1'b0;
`ifdef TRX_STATUS_MON_CLR_ON_RD_EN
        check("cor_second_data", rd_data, 32'h0000_0001);
`else
        check("cor_second_data", rd_data, 32'h0000_0003);
`endif

        // Asynchronous reset mid-stretch and mid-count
        evt_crc[0] = 1'b1;
        tick();
        evt_crc[0] = 1'b0;
        check("pre_rst_act0", led[2], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", led, 0);
        check("arst_sat_led", sat_led, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_valid", rd_valid, 0);
        #3;
        rst_n = 1'b1;
        do_read(2'd0, 32'h0000_0000, "post_rst_ch0");
        check("post_rst_hb", led[0], 0);
        check("post_rst_act0", led[2], 0);
        do_read(2'd1, 32'h0000_0000, "post_rst_ch1");
        pulse(1, 1'b0);
        do_read(2'd1, 32'h0000_0001, "resume_ch1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
